kernel_load: RTL

KERNEL_LOAD -- requirements
Module: kernel_load

---
 rtl/kernel_load.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/kernel_load.sv
// Kernel loader: gathers narrow stream beats into wide kernel words and writes
// one contiguous region of kernel memory per command, tracking the running base.
module kernel_load #(
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int DEPTH_NB   = 16,
    parameter int STR_WIDTH  = 64,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,

    input  logic [MEM_AWIDTH-1:0]                    cmd_nb,
    input  logic                                     cmd_val,
    output logic                                     cmd_rdy,

    input  logic [STR_WIDTH-1:0]                     str_data,
    input  logic                                     str_val,
    output logic                                     str_rdy,

    output logic [MEM_AWIDTH-1:0]                    wr_cfg_end,
    output logic                                     wr_cfg_set,

    output logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0]   wr_data,
    output logic                                     wr_data_val,
    input  logic                                     wr_data_rdy,

    output logic [MEM_AWIDTH-1:0]                    done_start,
    output logic [MEM_AWIDTH-1:0]                    done_end,
    output logic                                     done_val
);

    localparam int W       = GROUP_NB * KER_WIDTH * DEPTH_NB;
    localparam int BEAT_NB = W / STR_WIDTH;
    localparam int BEAT_W  = (BEAT_NB > 1) ? $clog2(BEAT_NB) : 1;

    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEAT_NB - 1);
    localparam logic [MEM_AWIDTH-1:0] MIN_NB    = MEM_AWIDTH'(2);
    localparam logic [MEM_AWIDTH-1:0] ONE_A     = MEM_AWIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CFG,
        S_LOAD,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [MEM_AWIDTH-1:0]   base_q, base_d;
    logic [MEM_AWIDTH-1:0]   nb_q, nb_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [MEM_AWIDTH-1:0]   word_q, word_d;
    logic [W-1:0]            wr_data_q, wr_data_d;
    logic                    wr_data_val_q, wr_data_val_d;
    logic [MEM_AWIDTH-1:0]   wr_cfg_end_q, wr_cfg_end_d;
    logic                    wr_cfg_set_q, wr_cfg_set_d;
    logic [MEM_AWIDTH-1:0]   done_start_q, done_start_d;
    logic [MEM_AWIDTH-1:0]   done_end_q, done_end_d;
    logic                    done_val_q, done_val_d;
    logic                    cmd_rdy_q, cmd_rdy_d;

    logic                    str_acc;
    logic                    word_acc;

    // NOTE: every variable gets its default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        nb_d          = nb_q;
        beat_d        = beat_q;
        word_d        = word_q;
        wr_data_d     = wr_data_q;
        wr_data_val_d = wr_data_val_q;
        wr_cfg_end_d  = wr_cfg_end_q;
        done_start_d  = done_start_q;
        done_end_d    = done_end_q;

        str_acc  = (state_q == S_LOAD) && !wr_data_val_q && str_val;
        word_acc = (state_q == S_LOAD) && wr_data_val_q && wr_data_rdy;

        unique case (state_q)
            S_IDLE: begin
                // Commands shorter than bias plus one kernel word are consumed silently.
                if (cmd_val && cmd_rdy_q && (cmd_nb >= MIN_NB)) begin
                    nb_d         = cmd_nb;
                    wr_cfg_end_d = base_q + cmd_nb;
                    beat_d       = '0;
                    word_d       = '0;
                    state_d      = S_CFG;
                end
            end
            S_CFG: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (str_acc) begin
                    // Shifting in from the top leaves the first beat in the LSBs.
                    wr_data_d = {str_data, wr_data_q[W-1:STR_WIDTH]};
                    if (beat_q == LAST_BEAT) begin
                        beat_d        = '0;
                        wr_data_val_d = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
                if (word_acc) begin
                    wr_data_val_d = 1'b0;
                    word_d        = word_q + ONE_A;
                    if ((word_q + ONE_A) == nb_q) begin
                        done_start_d = base_q;
                        done_end_d   = base_q + nb_q - ONE_A;
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                base_d  = base_q + nb_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake/pulse outputs are registered from the upcoming state.
        cmd_rdy_d    = (state_d == S_IDLE);
        wr_cfg_set_d = (state_d == S_CFG);
        done_val_d   = (state_d == S_DONE);
    end

    // NOTE: state registers use non-blocking assignments so all of them update
    // together from values sampled at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            nb_q          <= '0;
            beat_q        <= '0;
            word_q        <= '0;
            wr_data_q     <= '0;
            wr_data_val_q <= 1'b0;
            wr_cfg_end_q  <= '0;
            wr_cfg_set_q  <= 1'b0;
            done_start_q  <= '0;
            done_end_q    <= '0;
            done_val_q    <= 1'b0;
            cmd_rdy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            nb_q          <= nb_d;
            beat_q        <= beat_d;
            word_q        <= word_d;
            wr_data_q     <= wr_data_d;
            wr_data_val_q <= wr_data_val_d;
            wr_cfg_end_q  <= wr_cfg_end_d;
            wr_cfg_set_q  <= wr_cfg_set_d;
            done_start_q  <= done_start_d;
            done_end_q    <= done_end_d;
            done_val_q    <= done_val_d;
            cmd_rdy_q     <= cmd_rdy_d;
        end
    end

    assign cmd_rdy     = cmd_rdy_q;
    assign str_rdy     = (state_q == S_LOAD) && !wr_data_val_q;
    assign wr_cfg_end  = wr_cfg_end_q;
    assign wr_cfg_set  = wr_cfg_set_q;
    assign wr_data     = wr_data_q;
    assign wr_data_val = wr_data_val_q;
    assign done_start  = done_start_q;
    assign done_end    = done_end_q;
    assign done_val    = done_val_q;

endmodule
